// File: rtl/combo_pkg.sv
// ============================================================================
// Module : combo_pkg
// Brief  : Shared widths, defaults, FSM encoding and digit helpers for the
//          COMBO_ALU sequencer.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package combo_pkg;

  localparam int DIGIT_W     = 5;
  localparam int COMBO_MOD   = 30;
  localparam int DEF_ALU_LAT = 4;
  localparam int DEF_LOAD_AT = 2;

  typedef logic [DIGIT_W-1:0] digit_t;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ISSUE  = 3'd1,
    ST_WAIT   = 3'd2,
    ST_CHECK  = 3'd3,
    ST_RESULT = 3'd4,
    ST_LOCK   = 3'd5
  } state_t;

  // A digit the ALU's modulo-30 arithmetic does not define.
  function automatic logic digit_out_of_range(input digit_t d);
    return d >= digit_t'(COMBO_MOD);
  endfunction

endpackage

`default_nettype wire

// File: rtl/combo_alu_sequencer_if.sv
// ============================================================================
// Module : combo_alu_sequencer_if
// Brief  : Keypad-side request/key bus plus the COMBO_ALU operand/result bus
//          and status outputs of the sequencer.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface combo_alu_sequencer_if #(
  parameter int FAIL_W = 2
);
  import combo_pkg::*;

  logic              start;
  digit_t            digit0;
  digit_t            digit1;
  digit_t            digit2;
  logic              key_wr;
  digit_t            key0;
  digit_t            key1;
  digit_t            key2;
  digit_t            alu_out0;
  digit_t            alu_out1;
  digit_t            alu_out2;
  digit_t            alu_a;
  digit_t            alu_b;
  digit_t            alu_c;
  logic              alu_load;
  logic              busy;
  logic              done;
  logic              pass;
  logic              locked;
  logic [FAIL_W-1:0] fail_cnt;

  // Front end / ALU side: drives requests and ALU results, observes status.
  modport master (
    output start, digit0, digit1, digit2,
    output key_wr, key0, key1, key2,
    output alu_out0, alu_out1, alu_out2,
    input  alu_a, alu_b, alu_c, alu_load,
    input  busy, done, pass, locked, fail_cnt
  );

  // Sequencer side.
  modport slave (
    input  start, digit0, digit1, digit2,
    input  key_wr, key0, key1, key2,
    input  alu_out0, alu_out1, alu_out2,
    output alu_a, alu_b, alu_c, alu_load,
    output busy, done, pass, locked, fail_cnt
  );

endinterface

`default_nettype wire

// File: rtl/lock_timer.sv
// ============================================================================
// Module : lock_timer
// Brief  : Loadable down-counter; expire is high during the last enabled
//          cycle of a CYCLES-long window started by load.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lock_timer #(
  parameter int CYCLES = 16
) (
  input  wire logic clk,
  input  wire logic rst,
  input  wire logic load,
  input  wire logic en,
  output logic      expire
);

  localparam int W = (CYCLES > 1) ? $clog2(CYCLES) : 1;

  logic [W-1:0] cnt;

  // Load CYCLES-1 so that counts CYCLES-1..0 span exactly CYCLES cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= W'(CYCLES - 1);
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign expire = en && (cnt == '0);

endmodule

`default_nettype wire

// File: rtl/combo_alu_sequencer.sv
// ============================================================================
// Module : combo_alu_sequencer
// Brief  : Sequences one combination check through COMBO_ALU (adder, divider,
//          LFSR, subtractors), compares the offsets with a programmed key,
//          tracks consecutive failures and enforces a timed lockout.
//          Optional macro COMBO_RANGE_CHECK_EN: a start with any digit above
//          29 skips the ALU and fails in two cycles.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module combo_alu_sequencer
  import combo_pkg::*;
#(
  parameter int ALU_LAT     = DEF_ALU_LAT,
  parameter int LOAD_AT     = DEF_LOAD_AT,
  parameter int MAX_FAIL    = 3,
  parameter int LOCK_CYCLES = 16,
  parameter int FAIL_W      = 2
) (
  input  wire logic             CLK,
  input  wire logic             RST,
  combo_alu_sequencer_if.slave  bus
);

  localparam int CNT_W = $clog2(ALU_LAT + 1);
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(ALU_LAT - 1);
  localparam logic [CNT_W-1:0] LOAD_CNT  = CNT_W'(LOAD_AT);
  localparam logic [FAIL_W-1:0] FAIL_MAX = FAIL_W'(MAX_FAIL);

  state_t            state;
  state_t            state_nxt;
  logic [CNT_W-1:0]  wait_cnt;
  digit_t            a_r, b_r, c_r;
  digit_t            key0_r, key1_r, key2_r;
  digit_t            smp0_r, smp1_r, smp2_r;
  logic              bad_r;
  logic              pass_r;
  logic [FAIL_W-1:0] fail_r;
  logic [FAIL_W-1:0] fail_nxt;
  logic              match;
  logic              digits_bad;
  logic              lock_load;
  logic              lock_expire;

`ifdef COMBO_RANGE_CHECK_EN
  assign digits_bad = digit_out_of_range(bus.digit0) ||
                      digit_out_of_range(bus.digit1) ||
                      digit_out_of_range(bus.digit2);
`else
  assign digits_bad = 1'b0;
`endif

  // Saturating increment of the consecutive-failure count.
  assign fail_nxt = (fail_r == {FAIL_W{1'b1}}) ? fail_r : fail_r + 1'b1;

  // An out-of-range request is forced to fail regardless of stale samples.
  assign match = !bad_r && (smp0_r == key0_r) && (smp1_r == key1_r) &&
                 (smp2_r == key2_r);

  // State register.
  always_ff @(posedge CLK) begin
    if (RST) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; key_wr has priority over start in IDLE.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: begin
        if (!bus.key_wr && bus.start) begin
          // A rejected request skips ISSUE/WAIT and reaches RESULT via CHECK.
          state_nxt = digits_bad ? ST_CHECK : ST_ISSUE;
        end
      end
      ST_ISSUE:  state_nxt = ST_WAIT;
      ST_WAIT: begin
        if (wait_cnt == WAIT_LAST) state_nxt = ST_CHECK;
      end
      ST_CHECK:  state_nxt = ST_RESULT;
      ST_RESULT: begin
        if (!pass_r && (fail_nxt >= FAIL_MAX)) state_nxt = ST_LOCK;
        else                                   state_nxt = ST_IDLE;
      end
      ST_LOCK: begin
        if (lock_expire) state_nxt = ST_IDLE;
      end
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Datapath registers: key, held operands, wait counter, samples, result.
  always_ff @(posedge CLK) begin
    if (RST) begin
      a_r      <= '0;
      b_r      <= '0;
      c_r      <= '0;
      key0_r   <= '0;
      key1_r   <= '0;
      key2_r   <= '0;
      smp0_r   <= '0;
      smp1_r   <= '0;
      smp2_r   <= '0;
      wait_cnt <= '0;
      bad_r    <= 1'b0;
      pass_r   <= 1'b0;
      fail_r   <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (bus.key_wr) begin
            key0_r <= bus.key0;
            key1_r <= bus.key1;
            key2_r <= bus.key2;
          end else if (bus.start) begin
            a_r   <= bus.digit0;
            b_r   <= bus.digit1;
            c_r   <= bus.digit2;
            bad_r <= digits_bad;
          end
        end
        ST_ISSUE: wait_cnt <= '0;
        ST_WAIT: begin
          wait_cnt <= wait_cnt + 1'b1;
          if (wait_cnt == WAIT_LAST) begin
            smp0_r <= bus.alu_out0;
            smp1_r <= bus.alu_out1;
            smp2_r <= bus.alu_out2;
          end
        end
        ST_CHECK:  pass_r <= match;
        ST_RESULT: fail_r <= pass_r ? '0 : fail_nxt;
        ST_LOCK: begin
          if (lock_expire) fail_r <= '0;
        end
        default: ;
      endcase
    end
  end

  assign lock_load = (state == ST_RESULT) && (state_nxt == ST_LOCK);

  lock_timer #(
    .CYCLES (LOCK_CYCLES)
  ) u_lock_timer (
    .clk    (CLK),
    .rst    (RST),
    .load   (lock_load),
    .en     (state == ST_LOCK),
    .expire (lock_expire)
  );

  // Status and ALU control outputs decoded from state.
  always_comb begin
    bus.alu_a    = a_r;
    bus.alu_b    = b_r;
    bus.alu_c    = c_r;
    bus.alu_load = (state == ST_WAIT) && (wait_cnt == LOAD_CNT);
    bus.busy     = (state != ST_IDLE);
    bus.done     = (state == ST_RESULT);
    bus.pass     = pass_r;
    bus.locked   = (state == ST_LOCK);
    bus.fail_cnt = fail_r;
  end

endmodule

`default_nettype wire

// File: tb/tb_combo_alu_sequencer.sv
// ============================================================================
// Module : tb_combo_alu_sequencer
// Brief  : Directed bench for combo_alu_sequencer with an ALU stub returning
//          3,7,11 and a pass/fail scoreboard queue.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_combo_alu_sequencer;
  import combo_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  combo_alu_sequencer_if #(.FAIL_W(2)) bus ();

  combo_alu_sequencer #(
    .ALU_LAT     (4),
    .LOAD_AT     (2),
    .MAX_FAIL    (3),
    .LOCK_CYCLES (16),
    .FAIL_W      (2)
  ) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;
  bit exp_q[$];

  int done_cyc, loads, load_cyc, held_bad, n, dones;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic prog_key(input int k0, input int k1, input int k2);
    bus.key0   = 5'(k0);
    bus.key1   = 5'(k1);
    bus.key2   = 5'(k2);
    bus.key_wr = 1'b1;
    tick();
    bus.key_wr = 1'b0;
  endtask

  // Pop the expected pass flag for the done pulse being observed now.
  task automatic sb_check(input string tag);
    bit e;
    if (exp_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'(1), 32'(0));
    end else begin
      e = exp_q.pop_front();
      chk(tag, 32'(bus.pass), 32'(e));
    end
  endtask

  // Launch a check and follow it until done (bounded). Digit inputs are
  // scrambled after the launch to prove the operands are held internally.
  task automatic run_check(input int da, input int db, input int dc, input int mid_start,
                           output int dcyc, output int nload, output int lcyc, output int hbad);
    bus.digit0 = 5'(da);
    bus.digit1 = 5'(db);
    bus.digit2 = 5'(dc);
    bus.start  = 1'b1;
    tick();
    bus.start  = 1'b0;
    bus.digit0 = 5'(da + 1);
    bus.digit1 = 5'(db + 2);
    bus.digit2 = 5'(dc + 3);
    dcyc = 0; nload = 0; lcyc = 0; hbad = 0;
    for (int c = 1; c <= 30 && dcyc == 0; c++) begin
      if (bus.alu_load === 1'b1) begin nload++; lcyc = c; end
      if (bus.alu_a !== 5'(da) || bus.alu_b !== 5'(db) || bus.alu_c !== 5'(dc)) hbad++;
      if (bus.done === 1'b1) dcyc = c;
      bus.start = (c == mid_start);
      if (dcyc == 0) tick();
    end
    bus.start = 1'b0;
  endtask

  task automatic count_dones(input int cycles, output int nd);
    nd = 0;
    for (int c = 0; c < cycles; c++) begin
      if (bus.done === 1'b1 || bus.busy === 1'b1) nd++;
      tick();
    end
  endtask

  initial begin
    bus.start = 0; bus.key_wr = 0;
    bus.digit0 = 0; bus.digit1 = 0; bus.digit2 = 0;
    bus.key0 = 0; bus.key1 = 0; bus.key2 = 0;
    bus.alu_out0 = 5'd3; bus.alu_out1 = 5'd7; bus.alu_out2 = 5'd11;

    // Reset state
    rst = 1'b1;
    tick(); tick();
    chk("rst_alu_abc", 32'({bus.alu_a, bus.alu_b, bus.alu_c}), 32'(0));
    chk("rst_alu_load", 32'(bus.alu_load), 32'(0));
    chk("rst_busy", 32'(bus.busy), 32'(0));
    chk("rst_done", 32'(bus.done), 32'(0));
    chk("rst_pass", 32'(bus.pass), 32'(0));
    chk("rst_locked", 32'(bus.locked), 32'(0));
    chk("rst_fail_cnt", 32'(bus.fail_cnt), 32'(0));
    rst = 1'b0;

    // Key program + pass
    prog_key(3, 7, 11);
    chk("keywr_busy", 32'(bus.busy), 32'(0));
    exp_q.push_back(1'b1);
    run_check(5, 10, 15, 0, done_cyc, loads, load_cyc, held_bad);
    chk("pass_latency", 32'(done_cyc), 32'(7));
    chk("pass_load_count", 32'(loads), 32'(1));
    chk("pass_load_cycle", 32'(load_cyc), 32'(4));
    chk("pass_held", 32'(held_bad), 32'(0));
    sb_check("pass_flag");
    tick();
    chk("pass_fail_cnt", 32'(bus.fail_cnt), 32'(0));
    chk("pass_busy_after", 32'(bus.busy), 32'(0));
    chk("pass_flag_held", 32'(bus.pass), 32'(1));

    // Fail
    prog_key(3, 7, 12);
    exp_q.push_back(1'b0);
    run_check(5, 10, 15, 0, done_cyc, loads, load_cyc, held_bad);
    chk("fail1_latency", 32'(done_cyc), 32'(7));
    sb_check("fail1_flag");
    tick();
    chk("fail1_fail_cnt", 32'(bus.fail_cnt), 32'(1));
    chk("fail1_busy_after", 32'(bus.busy), 32'(0));

    // Second fail with start pulsed mid-WAIT
    exp_q.push_back(1'b0);
    run_check(1, 2, 3, 3, done_cyc, loads, load_cyc, held_bad);
    chk("fail2_latency", 32'(done_cyc), 32'(7));
    chk("fail2_held", 32'(held_bad), 32'(0));
    sb_check("fail2_flag");
    tick();
    chk("fail2_fail_cnt", 32'(bus.fail_cnt), 32'(2));
    count_dones(12, dones);
    chk("midwait_no_second", 32'(dones), 32'(0));

    // Third fail enters lockout
    exp_q.push_back(1'b0);
    run_check(20, 21, 22, 0, done_cyc, loads, load_cyc, held_bad);
    sb_check("fail3_flag");
    tick();
    chk("lock_locked", 32'(bus.locked), 32'(1));
    chk("lock_fail_cnt", 32'(bus.fail_cnt), 32'(3));

    // start and key_wr during lock are ignored; lock lasts 16 cycles
    bus.key0 = 5'd3; bus.key1 = 5'd7; bus.key2 = 5'd11;
    bus.digit0 = 5'd5; bus.digit1 = 5'd10; bus.digit2 = 5'd15;
    n = 0; dones = 0;
    while (bus.locked === 1'b1 && n < 40) begin
      n++;
      if (bus.done === 1'b1) dones++;
      bus.start  = (n <= 2);
      bus.key_wr = (n <= 2);
      tick();
    end
    bus.start = 1'b0; bus.key_wr = 1'b0;
    chk("lock_duration", 32'(n), 32'(16));
    chk("lock_no_done", 32'(dones), 32'(0));
    chk("unlock_fail_cnt", 32'(bus.fail_cnt), 32'(0));
    chk("unlock_busy", 32'(bus.busy), 32'(0));
    // Key written during lock must not have taken: still 3,7,12
    exp_q.push_back(1'b0);
    run_check(5, 10, 15, 0, done_cyc, loads, load_cyc, held_bad);
    sb_check("postlock_key_kept");
    tick();
    chk("postlock_fail_cnt", 32'(bus.fail_cnt), 32'(1));

    // start together with key_wr: key latched, no check launched
    bus.key0 = 5'd3; bus.key1 = 5'd7; bus.key2 = 5'd11;
    bus.key_wr = 1'b1; bus.start = 1'b1;
    tick();
    bus.key_wr = 1'b0; bus.start = 1'b0;
    chk("collide_no_busy", 32'(bus.busy), 32'(0));
    tick();
    chk("collide_no_busy2", 32'(bus.busy), 32'(0));
    exp_q.push_back(1'b1);
    run_check(5, 10, 15, 0, done_cyc, loads, load_cyc, held_bad);
    sb_check("collide_key_latched");
    tick();
    chk("collide_fail_cnt", 32'(bus.fail_cnt), 32'(0));

    // Reset mid-check with nonzero fail count
    prog_key(3, 7, 12);
    exp_q.push_back(1'b0);
    run_check(5, 10, 15, 0, done_cyc, loads, load_cyc, held_bad);
    sb_check("prerst_flag");
    tick();
    chk("prerst_fail_cnt", 32'(bus.fail_cnt), 32'(1));
    bus.digit0 = 5'd7; bus.digit1 = 5'd8; bus.digit2 = 5'd9;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick(); tick();
    chk("prerst_busy", 32'(bus.busy), 32'(1));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_alu_abc", 32'({bus.alu_a, bus.alu_b, bus.alu_c}), 32'(0));
    chk("midrst_status", 32'({bus.alu_load, bus.busy, bus.done, bus.pass, bus.locked}), 32'(0));
    chk("midrst_fail_cnt", 32'(bus.fail_cnt), 32'(0));
    count_dones(12, dones);
    chk("midrst_no_done", 32'(dones), 32'(0));

    // Out-of-range digits
    prog_key(3, 7, 11);
`ifdef COMBO_RANGE_CHECK_EN
    exp_q.push_back(1'b0);
`else
    exp_q.push_back(1'b1);
`endif
    run_check(31, 0, 0, 0, done_cyc, loads, load_cyc, held_bad);
    sb_check("range_flag");
`ifdef COMBO_RANGE_CHECK_EN
    chk("range_latency", 32'(done_cyc), 32'(2));
    chk("range_loads", 32'(loads), 32'(0));
    tick();
    chk("range_fail_cnt", 32'(bus.fail_cnt), 32'(1));
`else
    chk("range_latency", 32'(done_cyc), 32'(7));
    chk("range_loads", 32'(loads), 32'(1));
    tick();
    chk("range_fail_cnt", 32'(bus.fail_cnt), 32'(0));
`endif
    chk("sb_drained", 32'(exp_q.size()), 32'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/combo_alu_sequencer.md
Name: combo_alu_sequencer

Overview:
- Controller that sequences one combination check through the COMBO_ALU datapath: adder → divider → LFSR → three subtractors.
- Latches three user digits and holds them on the ALU inputs for the whole check. Pulses the ALU LOAD at the right pipeline stage, then samples the three offset outputs after the fixed latency.
- Compares the samples against a programmed key and reports pass/fail.
- Counts consecutive failures and enforces a timed lockout. Sits between the keypad/debounce front end and COMBO_ALU.

Parameters:
- ALU_LAT, 4, cycles from ISSUE to a valid out0..2 sample (adder 1 + divider 1 + LFSR 1 + subtractor 1).
- LOAD_AT, 2, WAIT count value at which alu_load is high for one cycle (the LFSR captures avgOut on that edge).
- MAX_FAIL, 3, consecutive failures that trigger lockout.
- LOCK_CYCLES, 16, lockout duration in clocks.
- FAIL_W, 2, width of fail_cnt; must hold MAX_FAIL.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  synchronous, active-high reset.
- start  in  1  request a check; sampled in IDLE only.
- digit0, digit1, digit2  in  5 each  user digits, legal range 0..29.
- key_wr  in  1  program key; sampled in IDLE only.
- key0, key1, key2  in  5 each  expected ALU offsets.
- alu_out0, alu_out1, alu_out2  in  5 each  COMBO_ALU out0..2.
- alu_a, alu_b, alu_c  out  5 each  to COMBO_ALU A/B/C.
- alu_load  out  1  to COMBO_ALU LOAD.
- busy  out  1  high whenever state is not IDLE.
- done  out  1  one-cycle pulse at result.
- pass  out  1  result flag, valid with done and held until the next done.
- locked  out  1  high in LOCK.
- fail_cnt  out  FAIL_W  consecutive failure count.

Behaviour:
- Reset: all outputs 0 (alu_a/b/c, alu_load, busy, done, pass, locked, fail_cnt); key registers 0; state IDLE; wait counter 0.
- RST asserted mid-operation aborts to IDLE with no done pulse.

State machine: IDLE, ISSUE, WAIT, CHECK, RESULT, LOCK.
- IDLE:
  - key_wr=1: latch key0..2 and stay in IDLE. If start is high in the same cycle, it is dropped (key_wr wins).
  - start=1 and key_wr=0: latch digit0..2 into alu_a/b/c and go to ISSUE.
- ISSUE: one cycle; clear wait counter; go to WAIT.
- WAIT:
  - Counter increments each cycle.
  - alu_load=1 only when counter==LOAD_AT.
  - When counter==ALU_LAT-1, register alu_out0..2 and go to CHECK.
  - alu_a/b/c stay stable from ISSUE through CHECK, because the subtractors re-read A/B/C.
- CHECK:
  - match = (sample0==key0) && (sample1==key1) && (sample2==key2).
  - Go to RESULT.
- RESULT:
  - done=1 and pass=match.
  - If match: fail_cnt←0, then IDLE.
  - If not match: fail_cnt saturating +1. If the new value ≥ MAX_FAIL, go to LOCK; else IDLE.
- LOCK:
  - locked=1 and a timer counts LOCK_CYCLES.
  - start and key_wr are ignored.
  - On expiry: fail_cnt←0, locked←0, then IDLE.

Timing and boundary rules:
- Latency from start sampled to done: 1 (ISSUE) + ALU_LAT (WAIT) + 1 (CHECK) + 1 (RESULT) = ALU_LAT+3 = 7 cycles at defaults.
- start held continuously: a new check launches from each IDLE visit. Checks never overlap.
- start or key_wr while busy: ignored, not queued.
- Digit values: all arithmetic is compare-only; no wrap is applied here. The modulo-30 handling belongs to COMBO_ALU.

Optional Feature:
- Macro: COMBO_RANGE_CHECK_EN.
- Defined: in IDLE, a start with any digit >29 goes directly to RESULT with pass=0. alu_load is never pulsed, fail_cnt increments normally, and latency is 2 cycles.
- Undefined: digits pass to the ALU unchecked.

Decomposition:
- Package combo_pkg holds:
  - DIGIT_W=5
  - COMBO_MOD=30
  - the state enum/encodings
  - default ALU_LAT and LOAD_AT
- Sub-module lock_timer (load, count-down, expire pulse) is used for LOCK. The wait counter stays inline.

Test Plan (bench stub drives alu_out0..2=3,7,11, valid at the sample cycle):
- Key program + pass: key_wr with key=3,7,11; start with digits 5,10,15.
  → alu_a/b/c=5,10,15 held; alu_load high exactly once, 2 cycles after ISSUE; done at cycle 7 with pass=1; fail_cnt=0.
- Fail: key=3,7,12; start.
  → done with pass=0; fail_cnt=1; busy low the next cycle.
- Lockout: three failing starts.
  → after the third done: locked=1, fail_cnt=3.
  → a start and a key_wr issued during lock have no effect.
  → locked drops after 16 cycles and fail_cnt=0.
- Collisions: start together with key_wr in IDLE → key latched, no check. start asserted mid-WAIT → no second done.
- Reset mid-check: RST during WAIT → all outputs 0 the next cycle, no done pulse, IDLE.
- COMBO_RANGE_CHECK_EN: digits 31,0,0 → done after 2 cycles with pass=0, no alu_load pulse, fail_cnt+1. Without the macro, the check runs the full 7 cycles.
